debug_display_ctrl: RTL and testbench
=====================================

Name: debug_display_ctrl

Overview:
- Parametrised status display controller for the Basys3 board.
- Takes NUM_CH probe buses of PROBE_W bits from the TPU top level, such as MLP state, accumulators and UART controller state.
- Shows a switch-selected 16-bit page of a switch-selected channel on the 16 LEDs and, as hex, on the 4-digit 7-segment display.
- A debounced button freezes a snapshot of all probes so the frozen data can be browsed page by page.

Parameters:
- NUM_CH, 4: number of probe channels; 1..16.
- PROBE_W, 32: width of each probe channel; 1..256.
- REFRESH_DIV, 100000: clk_100mhz cycles per digit slot; 100000 gives 1 kHz per digit at 100 MHz; must be ≥2.
- DEBOUNCE_CYC, 1000000: consecutive stable cycles needed to accept a button change (10 ms); must be ≥2.

Ports:
- clk_100mhz  input  1  system clock, 100 MHz.
- rst  input  1  reset: synchronous, active-high; clock clk_100mhz.
- probe_bus  input  NUM_CH*PROBE_W  channel c occupies bits [c*PROBE_W +: PROBE_W]; synchronous to clk_100mhz.
- sw  input  16  raw asynchronous switches.
- btn_freeze  input  1  raw asynchronous push button, active-high.
- led  output  16  registered LED drive.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low, one-cold; an[0] is the rightmost digit.
- frozen  output  1  high while the snapshot is displayed.

Behaviour:
- Synchronisers
  - sw and btn_freeze each pass through a 2-flop synchroniser; these flops reset to 0.
- Selection
  - ch_sel = sw_s[15:12]; pg_sel = sw_s[11:8].
  - Selected word = bits [pg_sel*16 +: 16] of the channel.
  - Bits beyond PROBE_W read as 0.
  - ch_sel ≥ NUM_CH yields 16'h0000.
- Data source
  - frozen=0: live probe_bus.
  - frozen=1: snap_reg, a NUM_CH*PROBE_W snapshot.
- Latency
  - probe_bus → led: 1 cycle.
  - sw → led: 3 cycles (2 sync + 1 reg).
  - led → seg for the digit currently lit: ≤1 extra cycle.
- Debouncer
  - stable_q holds the accepted button state; cnt counts 0..DEBOUNCE_CYC-1.
  - If btn_s ≠ stable_q, cnt increments; when cnt reaches DEBOUNCE_CYC-1, stable_q ← btn_s and cnt ← 0.
  - If btn_s = stable_q, cnt ← 0. Glitches shorter than DEBOUNCE_CYC are therefore rejected.
- Freeze FSM, states LIVE and FROZEN
  - A rising edge of stable_q (a single-cycle pulse) toggles the state.
  - LIVE → FROZEN: snap_reg ← probe_bus value present in that same cycle.
  - FROZEN → LIVE: live display resumes on the next cycle.
  - frozen = (state == FROZEN), registered.
  - Probe changes on the capture cycle: the pre-edge sampled value is captured.
- Refresh scanner
  - rcnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit ← digit+1 (2-bit, 3→0).
  - an = ~(4'b0001 << digit).
  - seg = hex7(word[digit*4 +: 4]), using standard hex glyphs 0-9 and A-F; 'b' and 'd' are lowercase.
  - seg and an update in the same cycle, so there is no mixed-digit cycle.
- dp
  - Low (lit) only when digit==3 and frozen=1; otherwise 1.
- Reset values
  - led=16'h0000, seg=7'h7F, dp=1, an=4'hF, frozen=0.
  - state=LIVE; snap_reg, rcnt, digit, cnt and stable_q = 0.
  - First cycle after rst deasserts: an=4'b1110.
- Reset mid-operation
  - rst during FROZEN clears to LIVE and zeroes snap_reg.
  - rst during a debounce count discards the pending edge.
  - A button held through reset registers as a press once DEBOUNCE_CYC cycles have elapsed after release of rst.

Optional Feature:
- Macro: DEBUG_DISPLAY_TRIG_CAPTURE_EN.
- When defined:
  - Adds input trig (1 bit, synchronous to clk_100mhz).
  - sw_s[0] is the arm bit.
  - In LIVE with arm=1, a rising edge of trig (registered edge detect) forces LIVE→FROZEN with the same snapshot rule; trig is ignored in FROZEN.
  - A trig edge and a button edge in the same cycle produce a single freeze.
  - Unfreezing is by button only.
- When undefined:
  - The trig port is absent and sw[0] is ignored.
  - Behaviour is exactly as above.

Test Plan (NUM_CH=4, PROBE_W=32, REFRESH_DIV=8, DEBOUNCE_CYC=16):
- Live select: probe ch2=32'hDEAD_BEEF, sw=16'h2000 → led=16'hBEEF 3 cycles later; sw=16'h2100 → led=16'hDEAD.
- Out of range: sw=16'h2200 (page 2) → led=0; sw=16'h7000 (ch7) → led=0.
- 7-seg scan: word 16'h12AB → an sequence 1110,1101,1011,0111, each held 8 cycles, with seg = glyphs b, A, 2, 1; dp=1 throughout.
- Debounce: 10-cycle button pulse → frozen stays 0. 30-cycle press → frozen=1 within 2+16+1 cycles of the press, dp=0 on digit 3. Probe then changed to 32'h0 → led unchanged. Second 30-cycle press → live.
- Reset while frozen: rst for 1 cycle → frozen=0, led=0, an=4'hF, seg=7'h7F; next cycle an=4'b1110.
- With DEBUG_DISPLAY_TRIG_CAPTURE_EN:
  - sw[0]=1, ch0=32'h0000_00AA, trig pulse → frozen=1 and led holds 16'h00AA after ch0 changes.
  - sw[0]=0 → a trig pulse has no effect.

Source files
------------

// File: rtl/debug_display_ctrl.sv
// rtl/debug_display_ctrl.sv - probe status display controller for Basys3 LEDs and 7-segment display
//
// Purpose:
//   Shows a switch-selected 16-bit page of a switch-selected probe channel on
//   the 16 LEDs and, as four hex digits, on the multiplexed 7-segment display.
//   A debounced push button toggles between live probes and a frozen snapshot
//   of all channels. The frozen snapshot can still be browsed page by page.
//
// Ports:
//   clk_100mhz  in   system clock
//   rst         in   synchronous, active-high reset
//   probe_bus   in   NUM_CH*PROBE_W probe bits, channel c at [c*PROBE_W +: PROBE_W]
//   sw          in   raw switches: [15:12] channel, [11:8] page, [0] trigger arm (optional)
//   btn_freeze  in   raw push button, active-high
//   trig        in   capture trigger, present only with DEBUG_DISPLAY_TRIG_CAPTURE_EN
//   led         out  registered 16-bit selected word
//   seg         out  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low, lit on the leftmost digit while frozen
//   an          out  digit anodes, active-low one-cold, an[0] is the rightmost digit
//   frozen      out  high while the snapshot is displayed
//
// Optional feature macro: DEBUG_DISPLAY_TRIG_CAPTURE_EN
//   Adds the trig input. With sw[0] set, a rising edge of trig freezes the
//   display exactly like a button press. Unfreezing stays button-only.

module debug_display_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int PROBE_W      = 32,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic                      clk_100mhz,
  input  logic                      rst,
  input  logic [NUM_CH*PROBE_W-1:0] probe_bus,
  input  logic [15:0]               sw,
  input  logic                      btn_freeze,
`ifdef DEBUG_DISPLAY_TRIG_CAPTURE_EN
  input  logic                      trig,
`endif
  output logic [15:0]               led,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [3:0]                an,
  output logic                      frozen
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int BUS_W  = NUM_CH * PROBE_W;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [15:0] sw_meta_q;
  logic [15:0] sw_s_q;
  logic        btn_meta_q;
  logic        btn_s_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      btn_meta_q <= btn_freeze;
      btn_s_q    <= btn_meta_q;
    end
  end

  logic [3:0] ch_sel;
  logic [3:0] pg_sel;
  assign ch_sel = sw_s_q[15:12];
  assign pg_sel = sw_s_q[11:8];

  // ---------------------------------------------------------------------------
  // Button debouncer: accept a new level only after DEBOUNCE_CYC consecutive
  // cycles of disagreement with the accepted level.
  // ---------------------------------------------------------------------------
  logic [DEB_W-1:0] cnt_q;
  logic             stable_q;
  logic             stable_prev_q;
  logic             btn_rise;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      stable_prev_q <= stable_q;
      if (btn_s_q != stable_q) begin
        if (cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
          stable_q <= btn_s_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + DEB_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign btn_rise = stable_q & ~stable_prev_q;

  // ---------------------------------------------------------------------------
  // Optional trigger capture
  // ---------------------------------------------------------------------------
  logic trig_fire;

`ifdef DEBUG_DISPLAY_TRIG_CAPTURE_EN
  logic trig_prev_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      trig_prev_q <= 1'b0;
    end else begin
      trig_prev_q <= trig;
    end
  end

  assign trig_fire = sw_s_q[0] & trig & ~trig_prev_q;

  logic unused_sw;
  assign unused_sw = ^sw_s_q[7:1];
`else
  assign trig_fire = 1'b0;

  logic unused_sw;
  assign unused_sw = ^sw_s_q[7:0];
`endif

  // ---------------------------------------------------------------------------
  // Freeze FSM. The snapshot takes probe_bus as seen on the toggling edge, so
  // the first frozen cycle shows the same value the live path would have.
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic             frozen_q;
  logic [BUS_W-1:0] snap_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q  <= ST_LIVE;
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      case (state_q)
        ST_LIVE: begin
          // A simultaneous trigger and button edge is one freeze event.
          if (btn_rise | trig_fire) begin
            state_q  <= ST_FROZEN;
            frozen_q <= 1'b1;
            snap_q   <= probe_bus;
          end
        end
        ST_FROZEN: begin
          if (btn_rise) begin
            state_q  <= ST_LIVE;
            frozen_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word selection. The channel is zero-padded to 16 pages of 16 bits so
  // pages beyond PROBE_W read as zero; an out-of-range channel reads as zero.
  // ---------------------------------------------------------------------------
  logic [BUS_W-1:0]   src;
  logic [PROBE_W-1:0] chan;
  logic [255:0]       chan_pad;
  logic [15:0]        word_d;
  logic [15:0]        led_q;

  always_comb begin
    src  = frozen_q ? snap_q : probe_bus;
    chan = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 4'(c)) begin
        chan = src[c*PROBE_W +: PROBE_W];
      end
    end
    chan_pad                = '0;
    chan_pad[PROBE_W-1:0]   = chan;
    word_d                  = chan_pad[{pg_sel, 4'b0000} +: 16];
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= word_d;
    end
  end

  // ---------------------------------------------------------------------------
  // 7-segment refresh scanner. an, seg and dp are all registered from the
  // same digit_q, so they always change together.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [RCNT_W-1:0] rcnt_q;
  logic [1:0]        digit_q;
  logic [3:0]        an_q;
  logic [6:0]        seg_q;
  logic              dp_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      rcnt_q  <= '0;
      digit_q <= 2'd0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
        rcnt_q  <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        rcnt_q <= rcnt_q + RCNT_W'(1);
      end
      an_q  <= ~(4'b0001 << digit_q);
      seg_q <= hex7(led_q[{digit_q, 2'b00} +: 4]);
      dp_q  <= ~((digit_q == 2'd3) & frozen_q);
    end
  end

  assign led    = led_q;
  assign seg    = seg_q;
  assign dp     = dp_q;
  assign an     = an_q;
  assign frozen = frozen_q;

endmodule

// File: tb/tb_debug_display_ctrl.sv
// tb/tb_debug_display_ctrl.sv - directed self-checking bench for debug_display_ctrl

module tb_debug_display_ctrl;

  logic         clk_100mhz;
  logic         rst;
  logic [127:0] probe_bus;
  logic [15:0]  sw;
  logic         btn_freeze;
  logic         trig;
  logic [15:0]  led;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   an;
  logic         frozen;

  int n_checks = 0;
  int n_pass   = 0;

  debug_display_ctrl #(
    .NUM_CH      (4),
    .PROBE_W     (32),
    .REFRESH_DIV (8),
    .DEBOUNCE_CYC(16)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .probe_bus (probe_bus),
    .sw        (sw),
    .btn_freeze(btn_freeze),
`ifdef DEBUG_DISPLAY_TRIG_CAPTURE_EN
    .trig      (trig),
`endif
    .led       (led),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frozen    (frozen)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] val);
    probe_bus[c*32 +: 32] = val;
  endtask

  // Press for n cycles, release, then let the debouncer settle.
  task automatic press(input int n);
    btn_freeze = 1'b1;
    tick(n);
    btn_freeze = 1'b0;
    tick(40);
  endtask

  // Press and report whether frozen reaches want within 2+16+1 cycles.
  task automatic press_timed(input string tag, input logic want);
    int hit;
    hit = 0;
    btn_freeze = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i <= 19 && frozen == want) hit = 1;
    end
    btn_freeze = 1'b0;
    check(tag, hit, 1);
    tick(40);
  endtask

  task automatic wait_an(input logic [3:0] target, output int ok);
    ok = 0;
    for (int i = 0; i < 64 && ok == 0; i++) begin
      if (an == target) ok = 1;
      else tick(1);
    end
  endtask

  logic [3:0] an_exp [4];
  logic [6:0] seg_exp[4];
  int ok;

  initial begin
    an_exp[0]  = 4'b1110; an_exp[1]  = 4'b1101; an_exp[2]  = 4'b1011; an_exp[3]  = 4'b0111;
    seg_exp[0] = 7'h03;   seg_exp[1] = 7'h08;   seg_exp[2] = 7'h24;   seg_exp[3] = 7'h79;

    rst = 1'b1; probe_bus = '0; sw = '0; btn_freeze = 1'b0; trig = 1'b0;
    tick(3);
    check("rst_led", led, 16'h0000);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_an", an, 4'hF);
    check("rst_frozen", frozen, 1'b0);
    rst = 1'b0;
    tick(1);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'h40);

    // Live selection and latency
    set_ch(2, 32'hDEAD_BEEF);
    sw = 16'h2000;
    tick(2);
    check("sw_lat_2", led, 16'h0000);
    tick(1);
    check("live_lo", led, 16'hBEEF);
    sw = 16'h2100;
    tick(3);
    check("live_hi", led, 16'hDEAD);
    sw = 16'h2200;
    tick(3);
    check("page_oor", led, 16'h0000);
    sw = 16'h7000;
    tick(3);
    check("ch_oor", led, 16'h0000);
    sw = 16'h2000;
    tick(3);
    set_ch(2, 32'h1234_5678);
    tick(1);
    check("probe_lat", led, 16'h5678);

    // Scan
    probe_bus = '0;
    set_ch(0, 32'h0000_12AB);
    sw = 16'h0000;
    tick(4);
    check("scan_led", led, 16'h12AB);
    wait_an(4'b0111, ok);
    check("scan_sync_a", ok, 1);
    wait_an(4'b1110, ok);
    check("scan_sync_b", ok, 1);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("scan_an_d%0d_k%0d", d, k), an, an_exp[d]);
        check($sformatf("scan_seg_d%0d_k%0d", d, k), seg, seg_exp[d]);
        if (k == 0) check($sformatf("scan_dp_d%0d", d), dp, 1'b1);
        tick(1);
      end
    end
    check("scan_wrap_an", an, 4'b1110);

    // Debounce and freeze
    press(10);
    check("glitch_frozen", frozen, 1'b0);
    press_timed("freeze_lat", 1'b1);
    wait_an(4'b0111, ok);
    check("dp_wait", ok, 1);
    check("dp_frozen", dp, 1'b0);
    probe_bus = '0;
    tick(3);
    check("frozen_led", led, 16'h12AB);
    check("frozen_hold", frozen, 1'b1);
    press_timed("unfreeze_lat", 1'b0);
    check("live_again_led", led, 16'h0000);

    // Reset while frozen
    set_ch(0, 32'h0000_5555);
    press(30);
    check("refreeze", frozen, 1'b1);
    set_ch(0, 32'h0);
    tick(2);
    check("refreeze_led", led, 16'h5555);
    rst = 1'b1;
    tick(1);
    check("mid_rst_frozen", frozen, 1'b0);
    check("mid_rst_led", led, 16'h0000);
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_dp", dp, 1'b1);
    rst = 1'b0;
    tick(1);
    check("mid_rst_an_next", an, 4'b1110);
    tick(3);
    check("mid_rst_live_led", led, 16'h0000);

`ifdef DEBUG_DISPLAY_TRIG_CAPTURE_EN
    sw = 16'h0001;
    set_ch(0, 32'h0000_00AA);
    tick(4);
    trig = 1'b1;
    ok = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      trig = 1'b0;
      if (frozen) ok = 1;
    end
    check("trig_freeze", ok, 1);
    set_ch(0, 32'h0);
    tick(2);
    check("trig_led", led, 16'h00AA);
    press(30);
    check("trig_unfreeze", frozen, 1'b0);
    sw = 16'h0000;
    tick(4);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(4);
    check("trig_disarmed", frozen, 1'b0);
    check("trig_disarmed_led", led, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
